// File: rtl/pcie_descrambler.sv
// PCIe Gen1/Gen2 receive descrambler, 4 symbols per clock.
// Local Galois LFSR, COM resync, SKP freeze, one-cycle latency.
module pcie_descrambler #(
  parameter logic [15:0] SEED       = 16'hFFFF,
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter logic [7:0]  SKP_SYMBOL = 8'h1C
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  input  logic        valid_i,
  input  logic        scramble_disable_i,
  input  logic        realign_i,
  output logic [31:0] data_o,
  output logic [3:0]  datak_o,
  output logic        valid_o,
  output logic        locked_o
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  datak_q, datak_d;
  logic        valid_q, valid_d;

  // Eight Galois advances; returns {next_state, keystream_byte}.
  function automatic logic [23:0] adv8(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0]  ks;
    l  = s;
    ks = 8'h00;
    for (int k = 0; k < 8; k++) begin
      ks[k] = l[15];
      l     = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {l, ks};
  endfunction

  // Walk lanes 0..3 in time order, threading LFSR and lock through.
  always_comb begin
    logic [15:0] l;
    logic        lk;
    logic [7:0]  b;
    logic [23:0] a;
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    datak_d = datak_q;
    valid_d = 1'b0;
    l  = lfsr_q;
    lk = (state_q == LOCKED) && !realign_i;
    b  = 8'h00;
    a  = 24'h0;
    if (valid_i) begin
      valid_d = 1'b1;
      datak_d = datak_i;
      for (int n = 0; n < 4; n++) begin
        b = data_i[8*n +: 8];
        a = adv8(l);
        if (datak_i[n]) begin
          if (b == COM_SYMBOL) begin
            l  = SEED;
            lk = 1'b1;
          end else if (b != SKP_SYMBOL) begin
            l = a[23:8];
          end
          data_d[8*n +: 8] = b;
        end else begin
          data_d[8*n +: 8] = (lk && !scramble_disable_i)
                           ? (b ^ a[7:0]) : b;
          l = a[23:8];
        end
      end
      lfsr_d  = l;
      state_d = lk ? LOCKED : UNLOCKED;
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= UNLOCKED;
      lfsr_q  <= SEED;
      data_q  <= 32'h0;
      datak_q <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      datak_q <= datak_d;
      valid_q <= valid_d;
    end
  end

  assign data_o   = data_q;
  assign datak_o  = datak_q;
  assign valid_o  = valid_q;
  assign locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_pcie_descrambler.sv
// Directed-vector bench for pcie_descrambler.
// Expected values are hand-derived keystream bytes.
module tb_pcie_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [3:0]  dink;
  logic        vin;
  logic        dis;
  logic        realign;
  logic [31:0] dout;
  logic [3:0]  doutk;
  logic        vout;
  logic        locked;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcie_descrambler dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .data_i             (din),
    .datak_i            (dink),
    .valid_i            (vin),
    .scramble_disable_i (dis),
    .realign_i          (realign),
    .data_o             (dout),
    .datak_o            (doutk),
    .valid_o            (vout),
    .locked_o           (locked)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] d,
                      input logic [3:0]  k,
                      input logic        v,
                      input logic        ds,
                      input logic        ra,
                      input logic        r);
    @(negedge clk);
    din     = d;
    dink    = k;
    vin     = v;
    dis     = ds;
    realign = ra;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; din = '0; dink = '0;
    vin = 1'b0; dis = 1'b0; realign = 1'b0;

    step(32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_data", dout, 32'h0);
    chk("rst_k", {28'h0, doutk}, 32'h0);
    chk("rst_v", {31'h0, vout}, 32'h0);
    chk("rst_lock", {31'h0, locked}, 32'h0);

    step(32'h000000BC, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("com_data", dout, 32'hC017FFBC);
    chk("com_k", {28'h0, doutk}, 32'h1);
    chk("com_lock", {31'h0, locked}, 32'h1);
    chk("com_v", {31'h0, vout}, 32'h1);
    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ks2", dout, 32'h02E7B214);

    step(32'hC017FFBC, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rt1", dout, 32'h000000BC);
    step(32'h02E7B214, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rt2", dout, 32'h0);

    step(32'h1C1C00BC, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("skp1", dout, 32'h1C1CFFBC);
    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("skp2", dout, 32'hB214C017);

    step(32'h000000BC, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stl_com", dout, 32'hC017FFBC);
    for (int i = 0; i < 3; i++) begin
      step(32'h12345678, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stl_v", {31'h0, vout}, 32'h0);
      chk("stl_hold", dout, 32'hC017FFBC);
    end
    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stl_ks", dout, 32'h02E7B214);

    step(32'h000000BC, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dis_com", dout, 32'h000000BC);
    step(32'h0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dis_stl", {31'h0, vout}, 32'h0);
    step(32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dis_pass", dout, 32'h0);
    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dis_ks82", {24'h0, dout[7:0]}, 32'h82);

    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ra_data", dout, 32'h0);
    chk("ra_lock", {31'h0, locked}, 32'h0);
    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ul_data", dout, 32'h0);
    chk("ul_lock", {31'h0, locked}, 32'h0);
    step(32'h00BC0000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("l2_data", dout, 32'hFFBC0000);
    chk("l2_lock", {31'h0, locked}, 32'h1);

    step(32'h000000BC, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mrst_data", dout, 32'h0);
    chk("mrst_k", {28'h0, doutk}, 32'h0);
    chk("mrst_v", {31'h0, vout}, 32'h0);
    chk("mrst_lock", {31'h0, locked}, 32'h0);
    step(32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_data", dout, 32'h0);
    chk("post_lock", {31'h0, locked}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
